// File: rtl/fifo_rd_depacketizer.sv
// Read-side depacketizer: pops the async FIFO, strips length headers, streams payload.
// Optional statistics counters are enabled with `define FIFO_RD_DEPKT_STATS_EN.
module fifo_rd_depacketizer #(
   parameter int DATA_W = 8
`ifdef FIFO_RD_DEPKT_STATS_EN
 , parameter int CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rd_empty,
   output logic              rd_en,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              pkt_done
`ifdef FIFO_RD_DEPKT_STATS_EN
 , output logic [CNT_W-1:0]  pkt_cnt,
   output logic [CNT_W-1:0]  byte_cnt,
   output logic [CNT_W-1:0]  zero_len_cnt
`endif
);

   // state   | meaning
   // HDR     | next returned byte is a length header
   // PAYLOAD | next returned byte is payload; remaining bytes left in packet
   typedef enum logic {HDR, PAYLOAD} state_t;

   state_t            state;
   logic [DATA_W-1:0] remaining;
   logic              inflight;
   logic [DATA_W:0]   buf_mem [0:2];
   logic [1:0]        wr_ptr;
   logic [1:0]        rd_ptr;
   logic [1:0]        occ;
   logic [2:0]        credit;
   logic              push;
   logic              pop;
   logic              hdr_zero;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // A read in flight reserves a buffer slot even if it turns out to be a header.
   assign credit   = {1'b0, occ} + {2'b00, inflight};
   assign rd_en    = !reset && !rd_empty && (credit < 3'd3);
   assign push     = inflight && (state == PAYLOAD);
   assign hdr_zero = inflight && (state == HDR) && (rd_data == '0);
   assign m_valid  = (occ != 2'd0);
   assign {m_last, m_data} = buf_mem[rd_ptr];
   assign pop      = m_valid && m_ready;
   assign pkt_done = !reset && pop && m_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= HDR;
         remaining <= '0;
         inflight  <= 1'b0;
         wr_ptr    <= 2'd0;
         rd_ptr    <= 2'd0;
         occ       <= 2'd0;
         for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
      end else begin
         inflight <= rd_en;
         if (inflight) begin
            case (state)
               HDR: begin
                  if (rd_data != '0) begin
                     remaining <= rd_data;
                     state     <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  buf_mem[wr_ptr] <= {(remaining == DATA_W'(1)), rd_data};
                  wr_ptr          <= ptr_inc(wr_ptr);
                  remaining       <= remaining - DATA_W'(1);
                  if (remaining == DATA_W'(1)) state <= HDR;
               end
               default: state <= HDR;
            endcase
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

`ifdef FIFO_RD_DEPKT_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_cnt      <= '0;
         byte_cnt     <= '0;
         zero_len_cnt <= '0;
      end else begin
         if (pkt_done) pkt_cnt      <= pkt_cnt + CNT_W'(1);
         if (pop)      byte_cnt     <= byte_cnt + CNT_W'(1);
         if (hdr_zero) zero_len_cnt <= zero_len_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rd_depacketizer.sv
// Bench for fifo_rd_depacketizer: FIFO model, packet-parsing reference queue, per-cycle compare.
module tb_fifo_rd_depacketizer;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rd_data = 8'h00;
   logic       rd_empty = 1'b1;
   logic       rd_en;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic       m_last;
   logic       pkt_done;
`ifdef FIFO_RD_DEPKT_STATS_EN
   logic [15:0] pkt_cnt, byte_cnt, zero_len_cnt;
`endif

   always #5 clk = ~clk;

   fifo_rd_depacketizer #(.DATA_W(8)) dut (
      .clk(clk), .reset(reset), .rd_data(rd_data), .rd_empty(rd_empty), .rd_en(rd_en),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .pkt_done(pkt_done)
`ifdef FIFO_RD_DEPKT_STATS_EN
    , .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .zero_len_cnt(zero_len_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_done = 0;
   int n_reads = 0;
   logic [7:0] fifo_q[$];
   logic [8:0] exp_q[$];
   bit par_hdr = 1'b1;
   int par_rem = 0;
   logic [7:0] acc_data[$];
   bit         acc_last[$];
   int         acc_cyc[$];
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: parse the byte stream into expected {last,data} entries as it is written.
   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      rd_empty = 1'b0;
      if (par_hdr) begin
         if (b != 8'h00) begin
            par_rem = b;
            par_hdr = 1'b0;
         end
      end else begin
         exp_q.push_back({(par_rem == 1), b});
         par_rem--;
         if (par_rem == 0) par_hdr = 1'b1;
      end
   endtask

   task automatic tick();
      logic en, rs;
      @(negedge clk);
      en = rd_en;
      rs = reset;
      @(posedge clk);
      #1;
      if (rs) begin
         fifo_q.delete();
         rd_data = 8'h00;
      end else if (en && fifo_q.size() > 0) begin
         rd_data = fifo_q.pop_front();
         n_reads++;
      end
      rd_empty = (fifo_q.size() == 0);
      #1;
   endtask

   task automatic clear_stats();
      acc_data.delete();
      acc_last.delete();
      acc_cyc.delete();
      n_done = 0;
      n_reads = 0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int i = 0;
      while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !m_valid) && i < budget) begin
         tick();
         i++;
      end
      chk({name, "_drained"}, (fifo_q.size() == 0 && exp_q.size() == 0 && !m_valid), 1);
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         par_hdr = 1'b1;
         par_rem = 0;
         prev_stall = 1'b0;
      end else begin
         chk("push_when_full", (dut.occ == 2'd3) && dut.push, 0);
         if (prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_data);
         end
         if (exp_q.size() == 0) begin
            chk("idle_valid", m_valid, 0);
            chk("idle_pkt_done", pkt_done, 0);
         end else if (m_valid) begin
            chk("m_data", m_data, exp_q[0][7:0]);
            chk("m_last", m_last, exp_q[0][8]);
            chk("pkt_done", pkt_done, m_ready && exp_q[0][8]);
            if (m_ready) begin
               acc_data.push_back(m_data);
               acc_last.push_back(m_last);
               acc_cyc.push_back(cyc);
               void'(exp_q.pop_front());
            end
         end else begin
            chk("pkt_done_novalid", pkt_done, 0);
         end
         if (pkt_done) n_done++;
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      tick();
      tick();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 8'h00);
      chk("rst_m_last", m_last, 0);
      chk("rst_pkt_done", pkt_done, 0);
      chk("rst_rd_en", rd_en, 0);
      reset = 1'b0;
      tick();

      // single 3-byte packet
      clear_stats();
      m_ready = 1'b1;
      push_byte(8'h03); push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
      wait_idle("t1", 40);
      chk("t1_count", acc_data.size(), 3);
      if (acc_data.size() == 3) begin
         chk("t1_b0", acc_data[0], 8'hAA);
         chk("t1_b1", acc_data[1], 8'hBB);
         chk("t1_b2", acc_data[2], 8'hCC);
         chk("t1_last", {acc_last[0], acc_last[1], acc_last[2]}, 3'b001);
         chk("t1_gap0", acc_cyc[1] - acc_cyc[0], 1);
         chk("t1_gap1", acc_cyc[2] - acc_cyc[1], 1);
      end
      chk("t1_done", n_done, 1);
      chk("t1_reads", n_reads, 4);
      chk("t1_rd_en", rd_en, 0);

      // back-to-back packets
      clear_stats();
      push_byte(8'h02); push_byte(8'h11); push_byte(8'h22); push_byte(8'h01); push_byte(8'h33);
      wait_idle("t2", 40);
      chk("t2_count", acc_data.size(), 3);
      if (acc_data.size() == 3) begin
         chk("t2_data", {acc_data[0], acc_data[1], acc_data[2]}, 24'h112233);
         chk("t2_last", {acc_last[0], acc_last[1], acc_last[2]}, 3'b011);
         chk("t2_gap0", acc_cyc[1] - acc_cyc[0], 1);
         chk("t2_gap1", acc_cyc[2] - acc_cyc[1], 2);
      end
      chk("t2_done", n_done, 2);

      // backpressure fills the 3-entry buffer
      clear_stats();
      m_ready = 1'b0;
      push_byte(8'h05);
      for (int i = 1; i <= 5; i++) push_byte(8'(i));
      repeat (12) tick();
      chk("t3_rd_en", rd_en, 0);
      chk("t3_valid", m_valid, 1);
      chk("t3_head", m_data, 8'h01);
      chk("t3_fifo_left", fifo_q.size(), 2);
      m_ready = 1'b1;
      wait_idle("t3", 40);
      chk("t3_count", acc_data.size(), 5);
      if (acc_data.size() == 5) begin
         for (int i = 0; i < 5; i++) chk("t3_data", acc_data[i], i + 1);
         for (int i = 1; i < 5; i++) chk("t3_gap", acc_cyc[i] - acc_cyc[i-1], 1);
      end
      chk("t3_done", n_done, 1);

      // FIFO runs dry mid-packet
      clear_stats();
      push_byte(8'h04); push_byte(8'hC1); push_byte(8'hC2);
      repeat (12) tick();
      chk("t5_rd_en", rd_en, 0);
      chk("t5_valid", m_valid, 0);
      chk("t5_mid_count", acc_data.size(), 2);
      push_byte(8'hC3); push_byte(8'hC4);
      wait_idle("t5", 40);
      chk("t5_count", acc_data.size(), 4);
      if (acc_data.size() == 4) begin
         chk("t5_b3", acc_data[3], 8'hC4);
         chk("t5_last", {acc_last[0], acc_last[1], acc_last[2], acc_last[3]}, 4'b0001);
      end
      chk("t5_done", n_done, 1);

      // reset mid-packet
      clear_stats();
      push_byte(8'h06);
      for (int i = 1; i <= 6; i++) push_byte(8'hA0 + 8'(i));
      begin
         int i = 0;
         while (acc_data.size() < 2 && i < 30) begin
            tick();
            i++;
         end
      end
      chk("t6_two_bytes", acc_data.size() >= 2, 1);
      do_reset();
      chk("t6_valid_after_rst", m_valid, 0);
      chk("t6_rd_en_after_rst", rd_en, 0);
      clear_stats();
      push_byte(8'h05);
      for (int i = 1; i <= 5; i++) push_byte(8'hB0 + 8'(i));
      wait_idle("t6", 40);
      chk("t6_count", acc_data.size(), 5);
      if (acc_data.size() == 5) begin
         chk("t6_first", acc_data[0], 8'hB1);
         chk("t6_lastb", acc_data[4], 8'hB5);
      end
      chk("t6_done", n_done, 1);

      // zero-length headers are dropped
      do_reset();
      clear_stats();
      push_byte(8'h00); push_byte(8'h00); push_byte(8'h01); push_byte(8'h7E);
      wait_idle("t4", 40);
      chk("t4_count", acc_data.size(), 1);
      if (acc_data.size() == 1) begin
         chk("t4_data", acc_data[0], 8'h7E);
         chk("t4_last", acc_last[0], 1);
      end
      chk("t4_done", n_done, 1);
`ifdef FIFO_RD_DEPKT_STATS_EN
      chk("t4_zero_len_cnt", zero_len_cnt, 16'd2);
      chk("t4_pkt_cnt", pkt_cnt, 16'd1);
      chk("t4_byte_cnt", byte_cnt, 16'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
